// File: rtl/mmio_stream_fifo.sv
// ============================================================================
// mmio_stream_fifo : multi-channel MMIO-written FIFOs drained by valid/ready
//                    consumers, on the picorv32 native memory bus.
// Option macro     : MMIO_STREAM_FIFO_BLOCKING_WRITE_EN (stall writes to full)
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_stream_fifo #(
    parameter int          N_CHANNELS = 2,
    parameter int          DATA_WIDTH = 8,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mem_valid,
    input  logic [31:0]                      mem_addr,
    input  logic [31:0]                      mem_wdata,
    input  logic [3:0]                       mem_wstrb,
    output logic                             mem_ready,
    output logic [31:0]                      mem_rdata,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [N_CHANNELS-1:0]            out_valid,
    input  logic [N_CHANNELS-1:0]            out_ready
);

    localparam int              c_AW  = $clog2(DEPTH);
    localparam int              c_PW  = c_AW + 1;
    localparam int              c_CW  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [32:0]     c_END = {1'b0, BASE_ADDR} + 33'(16 * N_CHANNELS);
    localparam logic [c_PW-1:0] c_ONE = c_PW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_rdata;
    logic [31:0]       w_off;
    logic              w_hit;
    logic [c_CW-1:0]   w_ch;
    logic [1:0]        w_reg;
    logic              w_wr;
    logic              w_stall;
    logic              w_do;
    logic [N_CHANNELS-1:0] w_full;
    logic [31:0]       w_status [N_CHANNELS];
    logic              w_unused;

    assign w_off    = mem_addr - BASE_ADDR;
    assign w_hit    = mem_valid && (mem_addr >= BASE_ADDR) && ({1'b0, mem_addr} < c_END);
    assign w_ch     = w_off[4 +: c_CW];
    assign w_reg    = w_off[3:2];
    assign w_wr     = |mem_wstrb;
    assign w_unused = ^{w_off, mem_wdata};

`ifdef MMIO_STREAM_FIFO_BLOCKING_WRITE_EN
    // Hold the bus in IDLE until the target channel has room at cycle start.
    assign w_stall = w_hit && w_wr && (w_reg == 2'd0) && w_full[w_ch];
`else
    assign w_stall = 1'b0;
`endif

    assign w_do = (r_state == S_IDLE) && w_hit && !w_stall;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_do) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_do) begin
                r_rdata <= (!w_wr && (w_reg == 2'd1)) ? w_status[w_ch] : 32'd0;
            end
        end
    end

    assign mem_ready = (r_state == S_ACK);
    assign mem_rdata = mem_ready ? r_rdata : 32'd0;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [c_PW-1:0]       r_wr_ptr;
        logic [c_PW-1:0]       r_rd_ptr;
        logic [c_PW-1:0]       w_cnt;
        logic                  r_ovf;
        logic                  w_empty;
        logic                  w_sel;
        logic                  w_push;
        logic                  w_drop;
        logic                  w_flush;
        logic                  w_rdclr;
        logic                  w_pop;

        assign w_cnt     = r_wr_ptr - r_rd_ptr;
        assign w_empty   = (r_wr_ptr == r_rd_ptr);
        assign w_full[c] = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                           (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

        assign w_sel   = w_do && (w_ch == c_CW'(c));
        assign w_push  = w_sel && w_wr && (w_reg == 2'd0) && !w_full[c];
        assign w_drop  = w_sel && w_wr && (w_reg == 2'd0) && w_full[c];
        assign w_flush = w_sel && w_wr && (w_reg == 2'd2) && mem_wdata[0];
        assign w_rdclr = w_sel && !w_wr && (w_reg == 2'd1);
        assign w_pop   = out_valid[c] && out_ready[c];

        // Flush outranks any same-cycle push or pop on this channel.
        always_ff @(posedge clk) begin
            if (reset || w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
                if (w_drop)       r_ovf <= 1'b1;
                else if (w_rdclr) r_ovf <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= mem_wdata[DATA_WIDTH-1:0];
        end

        assign out_valid[c] = !w_empty;
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] =
            w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
        assign w_status[c] = {15'd0, 9'(w_cnt), 5'd0, r_ovf, w_full[c], w_empty};
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_stream_fifo.sv
// ============================================================================
// tb_mmio_stream_fifo : scoreboard bench for mmio_stream_fifo, with a
//                       queue-based model of each channel.
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_stream_fifo;

    localparam int          N     = 2;
    localparam int          DW    = 8;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq [N][$];
    bit            movf [N];
    logic [32:0]   ack_q [$];
    bit            acc_done = 1'b0;
    bit            rand_en  = 1'b0;

    mmio_stream_fifo #(
        .N_CHANNELS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard + model: samples at negedge, i.e. the values the next posedge sees.
    always @(negedge clk) begin
        if (!reset) begin
            logic [32:0] e;
            bit          hit, wr, stall, full_pre [N];
            bit          pushc [N], flushc [N];
            int          ch, rg;
            logic [31:0] st;

            if (mem_ready) begin
                if (ack_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_ack: got mem_ready=1 expected 0 at %0t", $time);
                end else begin
                    e = ack_q.pop_front();
                    if (e[32]) chk("rdata", mem_rdata, e[31:0]);
                end
            end

            for (int c = 0; c < N; c++) begin
                chk("out_valid", 32'(out_valid[c]), 32'(mq[c].size() != 0));
                if (mq[c].size() != 0) chk("out_data", 32'(out_data[c*DW +: DW]), 32'(mq[c][0]));
                full_pre[c] = (mq[c].size() == DEPTH);
                pushc[c]    = 1'b0;
                flushc[c]   = 1'b0;
            end

            hit = mem_valid && !acc_done && (mem_addr >= BASE) && (mem_addr < BASE + 16 * N);
            if (hit) begin
                ch = int'((mem_addr - BASE) / 16);
                rg = int'(((mem_addr - BASE) % 16) / 4);
                wr = (mem_wstrb != 4'd0);
                stall = 1'b0;
`ifdef MMIO_STREAM_FIFO_BLOCKING_WRITE_EN
                stall = wr && (rg == 0) && full_pre[ch];
`endif
                if (!stall) begin
                    acc_done = 1'b1;
                    if (!wr) begin
                        st = 32'd0;
                        if (rg == 1) begin
                            st = (32'(mq[ch].size()) << 8) | (32'(movf[ch]) << 2) |
                                 (32'(full_pre[ch]) << 1) | 32'(mq[ch].size() == 0);
                            movf[ch] = 1'b0;
                        end
                        ack_q.push_back({1'b1, st});
                    end else begin
                        ack_q.push_back({1'b0, 32'd0});
                        if (rg == 0) pushc[ch] = 1'b1;
                        if (rg == 2 && mem_wdata[0]) flushc[ch] = 1'b1;
                    end
                end
            end

            for (int c = 0; c < N; c++) begin
                if (flushc[c]) begin
                    mq[c].delete();
                    movf[c] = 1'b0;
                end else begin
                    if (mq[c].size() != 0 && out_ready[c]) void'(mq[c].pop_front());
                    if (pushc[c]) begin
                        if (full_pre[c]) movf[c] = 1'b1;
                        else mq[c].push_back(mem_wdata[DW-1:0]);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) out_ready = N'($urandom);
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [N-1:0] popm, input bit use_pop, input bit chk_lat,
                       output logic [31:0] rd);
        int k;
        bit got;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        if (use_pop) begin
            out_ready = popm;
            fork
                begin @(posedge clk); #1; out_ready = '0; end
            join_none
        end
        got = 1'b0;
        rd  = 32'd0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                rd  = mem_rdata;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout: got no mem_ready expected ack for addr %h", a);
        end else if (chk_lat) begin
`ifndef MMIO_STREAM_FIFO_BLOCKING_WRITE_EN
            chk("latency", 32'(k), 32'd2);
`endif
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = 4'd0;
        acc_done  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bus(a, d, 4'b0001, '0, 1'b0, 1'b1, rd);
    endtask

    task automatic rd_status(input int ch, output logic [31:0] rd);
        bus(BASE + 32'(16 * ch) + 32'd4, 32'd0, 4'd0, '0, 1'b0, 1'b1, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addrs [2];
        bit          bad;

        reset = 1'b1; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        mem_wstrb = 4'd0; out_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);

        rd_status(0, rd);
        chk("status_empty", rd, 32'h0000_0001);

        wr(BASE, 32'h41); wr(BASE, 32'h42); wr(BASE, 32'h43);
        rd_status(0, rd);
        chk("status_3", rd, 32'h0000_0300);
        @(posedge clk); #1 out_ready = 2'b01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drained_ch0", 32'(out_valid[0]), 32'd0);
        out_ready = '0;

`ifdef MMIO_STREAM_FIFO_BLOCKING_WRITE_EN
        for (int i = 0; i < 16; i++) wr(BASE + 32'h10, 32'(i));
        fork
            begin repeat (6) @(posedge clk); #1 out_ready = 2'b10; @(posedge clk); #1 out_ready = '0; end
        join_none
        wr(BASE + 32'h10, 32'h10);
        rd_status(1, rd);
        chk("status_full_blk", rd, 32'h0000_1002);
`else
        for (int i = 0; i < 17; i++) wr(BASE + 32'h10, 32'(i));
        rd_status(1, rd);
        chk("status_ovf", rd, 32'h0000_1006);
        rd_status(1, rd);
        chk("status_ovf_clr", rd, 32'h0000_1002);
`endif
        @(posedge clk); #1 out_ready = 2'b10;
        repeat (20) @(posedge clk);
        #1 out_ready = '0;

        for (int i = 0; i < 15; i++) wr(BASE, 32'($urandom));
        for (int i = 0; i < 41; i++) begin
            bus(BASE, 32'($urandom), 4'b0001, 2'b01, 1'b1, 1'b1, rd);
            if (i == 0 || i == 40) begin
                rd_status(0, rd);
                chk("status_pushpop", rd, 32'h0000_0F00);
            end
        end
        @(posedge clk); #1 out_ready = 2'b01;
        repeat (20) @(posedge clk);
        #1 out_ready = '0;

        for (int i = 0; i < 5; i++) wr(BASE, 32'h50 + 32'(i));
        bus(BASE + 32'd8, 32'd1, 4'b1111, 2'b01, 1'b1, 1'b1, rd);
        out_ready = 2'b01;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid[0]), 32'd0);
        rd_status(0, rd);
        chk("status_flush", rd, 32'h0000_0001);
        out_ready = '0;

        addrs[0] = BASE + 32'h20;
        addrs[1] = BASE - 32'd4;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            mem_valid = 1'b1; mem_addr = addrs[j]; mem_wstrb = 4'd0;
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (mem_ready) bad = 1'b1;
            end
            chk("miss_no_ack", 32'(bad), 32'd0);
            @(posedge clk); #1 mem_valid = 1'b0;
        end

        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int          ch, sel;
            logic [31:0] a, d;
            logic [3:0]  s;
            ch  = int'($urandom_range(0, N - 1));
            sel = int'($urandom_range(0, 7));
            d   = $urandom;
            s   = 4'($urandom_range(1, 15));
            if (sel < 4) a = BASE + 32'(16 * ch);
            else if (sel < 6) begin a = BASE + 32'(16 * ch) + 32'd4; s = 4'd0; end
            else if (sel == 6) begin
                a = BASE + 32'(16 * ch) + 32'd8;
                d[0] = ($urandom_range(0, 5) == 0);
            end else a = BASE + 32'(16 * ch) + 32'd12;
            bus(a, d, s, '0, 1'b0, 1'b1, rd);
        end
        rand_en = 1'b0;
        @(posedge clk); #1 out_ready = '1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
